// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the fetch stage and its bench.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/rv32_fetch_stage.sv
// RV32 instruction fetch: pc sequencing, one-entry stall hold buffer and
// redirect handling with a drain state for reads already on the bus.
module rv32_fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            branch_mispredicted_in,
  input  logic [XLEN-1:0] branch_target_in,
  output logic [XLEN-1:0] instr_address_out,
  output logic            instr_read_out,
  input  logic            instr_ready_in,
  input  logic [XLEN-1:0] instr_read_value_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out,
  output logic            valid_out
);

  fetch_state_e    state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [XLEN-1:0] pending_target, pending_target_d;
  logic            hold_valid, hold_valid_d;
  logic [XLEN-1:0] hold_pc, hold_pc_d;
  logic [XLEN-1:0] hold_instr, hold_instr_d;
  logic [XLEN-1:0] pc_out_d, instr_out_d;
  logic            valid_out_d;

  logic            complete;
  logic            load;
  logic [XLEN-1:0] load_pc, load_instr;

  // Bus request is driven straight from registered state.
  assign instr_address_out = pc;
  assign instr_read_out    = (state == ST_DRAIN) || !hold_valid;
  assign complete          = instr_read_out && instr_ready_in;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_RUN;
      pc             <= RESET_VECTOR;
      pending_target <= '0;
      hold_valid     <= 1'b0;
      hold_pc        <= '0;
      hold_instr     <= '0;
      pc_out         <= '0;
      instr_out      <= '0;
      valid_out      <= 1'b0;
    end else begin
      state          <= state_d;
      pc             <= pc_d;
      pending_target <= pending_target_d;
      hold_valid     <= hold_valid_d;
      hold_pc        <= hold_pc_d;
      hold_instr     <= hold_instr_d;
      pc_out         <= pc_out_d;
      instr_out      <= instr_out_d;
      valid_out      <= valid_out_d;
    end
  end

  always_comb begin
    state_d          = state;
    pc_d             = pc;
    pending_target_d = pending_target;
    hold_valid_d     = hold_valid;
    hold_pc_d        = hold_pc;
    hold_instr_d     = hold_instr;
    pc_out_d         = pc_out;
    instr_out_d      = instr_out;
    valid_out_d      = valid_out;
    load             = 1'b0;
    load_pc          = hold_pc;
    load_instr       = hold_instr;

    unique case (state)
      ST_RUN: begin
        if (branch_mispredicted_in) begin
          valid_out_d  = 1'b0;
          hold_valid_d = 1'b0;
          // A read still waiting on the bus must finish before we can move.
          if (instr_read_out && !instr_ready_in) begin
            pending_target_d = branch_target_in;
            state_d          = ST_DRAIN;
          end else begin
            pc_d = branch_target_in;
          end
        end else begin
          if (hold_valid) begin
            if (!stall_in) begin
              load         = 1'b1;
              hold_valid_d = 1'b0;
            end
          end else if (complete) begin
            pc_d = pc + 32'd4;
            if (stall_in) begin
              hold_valid_d = 1'b1;
              hold_pc_d    = pc;
              hold_instr_d = instr_read_value_in;
            end else begin
              load       = 1'b1;
              load_pc    = pc;
              load_instr = instr_read_value_in;
            end
          end

          if (flush_in) begin
            valid_out_d = 1'b0;
          end else if (stall_in) begin
            valid_out_d = valid_out;
          end else if (load) begin
            valid_out_d = 1'b1;
            pc_out_d    = load_pc;
            instr_out_d = load_instr;
          end else begin
            valid_out_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        valid_out_d = 1'b0;
        if (branch_mispredicted_in) begin
          pending_target_d = branch_target_in;
        end
        // Stale data is dropped; the newest redirect wins.
        if (complete) begin
          pc_d    = branch_mispredicted_in ? branch_target_in : pending_target;
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// Directed and randomized bench for rv32_fetch_stage with a transaction-level model.
module tb_rv32_fetch_stage;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_in, flush_in, branch_mispredicted_in;
  logic [31:0] branch_target_in;
  logic [31:0] instr_address_out;
  logic        instr_read_out;
  logic        instr_ready_in;
  logic [31:0] instr_read_value_in;
  logic [31:0] pc_out, instr_out;
  logic        valid_out;

  int total = 0;
  int bad   = 0;

  // Reference model: fetch address, whether a redirect is waiting on a stale
  // read, the target it is waiting for, the parked instruction and the
  // instruction currently presented to decode.
  logic [31:0] m_pc;
  bit          m_drain;
  logic [31:0] m_pend;
  bit          m_hv;
  logic [31:0] m_hpc, m_hin;
  bit          m_vo;
  logic [31:0] m_po, m_io;

  rv32_fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .stall_in               (stall_in),
    .flush_in               (flush_in),
    .branch_mispredicted_in (branch_mispredicted_in),
    .branch_target_in       (branch_target_in),
    .instr_address_out      (instr_address_out),
    .instr_read_out         (instr_read_out),
    .instr_ready_in         (instr_ready_in),
    .instr_read_value_in    (instr_read_value_in),
    .pc_out                 (pc_out),
    .instr_out              (instr_out),
    .valid_out              (valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check bus request, advance model, check outputs.
  task automatic step(input bit rst, input bit st, input bit fl, input bit br,
                      input logic [31:0] tg, input bit rdy, input logic [31:0] dat);
    bit          req, done, got;
    logic [31:0] got_pc, got_in;
    reset_n                = ~rst;
    stall_in               = st;
    flush_in               = fl;
    branch_mispredicted_in = br;
    branch_target_in       = tg;
    instr_ready_in         = rdy;
    instr_read_value_in    = dat;
    #1;
    req = m_drain || !m_hv;
    chk("addr", instr_address_out, m_pc);
    chk("read", 32'(instr_read_out), 32'(req));

    done = req && rdy;
    got  = 0; got_pc = '0; got_in = '0;
    if (rst) begin
      m_pc = 32'h0; m_drain = 0; m_pend = 0; m_hv = 0; m_vo = 0; m_po = 0; m_io = 0;
    end else if (m_drain) begin
      m_vo = 0;
      if (br) m_pend = tg;
      if (done) begin m_pc = m_pend; m_drain = 0; end
    end else if (br) begin
      m_vo = 0; m_hv = 0;
      if (req && !rdy) begin m_pend = tg; m_drain = 1; end
      else m_pc = tg;
    end else begin
      if (m_hv) begin
        if (!st) begin got = 1; got_pc = m_hpc; got_in = m_hin; m_hv = 0; end
      end else if (done) begin
        if (st) begin m_hv = 1; m_hpc = m_pc; m_hin = dat; end
        else begin got = 1; got_pc = m_pc; got_in = dat; end
        m_pc = m_pc + 32'd4;
      end
      if (fl) m_vo = 0;
      else if (!st) begin
        m_vo = got;
        if (got) begin m_po = got_pc; m_io = got_in; end
      end
    end

    @(posedge clk);
    #1;
    chk("valid", 32'(valid_out), 32'(m_vo));
    if (m_vo) begin
      chk("pc_out", pc_out, m_po);
      chk("instr_out", instr_out, m_io);
    end
  endtask

  task automatic fetch(input logic [31:0] dat);
    step(0, 0, 0, 0, 32'h0, 1, dat);
  endtask

  task automatic wait_bus;
    step(0, 0, 0, 0, 32'h0, 0, 32'hDEAD_BEEF);
  endtask

  initial begin
    m_pc = 0; m_drain = 0; m_pend = 0; m_hv = 0; m_hpc = 0; m_hin = 0;
    m_vo = 0; m_po = 0; m_io = 0;
    reset_n = 0; stall_in = 0; flush_in = 0; branch_mispredicted_in = 0;
    branch_target_in = 0; instr_ready_in = 0; instr_read_value_in = 0;

    // Reset
    step(1, 0, 0, 0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 1, 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_addr", instr_address_out, 32'h0);
    chk("rst_read", 32'(instr_read_out), 32'h1);

    // Back-to-back fetches
    fetch(RV32_NOP);     chk("seq_pc0", pc_out, 32'h0);
    fetch(32'h0000_0093); chk("seq_pc4", pc_out, 32'h4);
    fetch(32'h0000_0113); chk("seq_pc8", pc_out, 32'h8);
    chk("seq_in8", instr_out, 32'h0000_0113);
    fetch(32'h0000_0193);

    // Bus wait at 0x10
    repeat (3) begin
      wait_bus;
      chk("wait_addr", instr_address_out, 32'h10);
    end
    fetch(32'h0000_0213);
    chk("wait_pc", pc_out, 32'h10);
    chk("wait_vld", 32'(valid_out), 32'h1);

    fetch(32'h14); fetch(32'h18); fetch(32'h1C);

    // Stall on completion of 0x20
    step(0, 1, 0, 0, 32'h0, 1, 32'hAAAA_0020);
    chk("stall_read", 32'(instr_read_out), 32'h0);
    chk("stall_pc", pc_out, 32'h1C);
    step(0, 1, 0, 0, 32'h0, 1, 32'h0);
    chk("stall_read2", 32'(instr_read_out), 32'h0);
    step(0, 0, 0, 0, 32'h0, 1, 32'h0);
    chk("unstall_pc", pc_out, 32'h20);
    chk("unstall_in", instr_out, 32'hAAAA_0020);
    chk("resume_addr", instr_address_out, 32'h24);
    chk("resume_read", 32'(instr_read_out), 32'h1);

    fetch(32'h24); fetch(32'h28);
    // Flush discards a completed fetch but pc still advances
    step(0, 0, 1, 0, 32'h0, 1, 32'h2C);
    chk("flush_vld", 32'(valid_out), 32'h0);
    chk("flush_addr", instr_address_out, 32'h30);

    // Redirect while 0x30 waits, then drain
    step(0, 0, 0, 1, 32'h100, 0, 32'h0);
    wait_bus;
    step(0, 0, 0, 0, 32'h0, 1, 32'hBAD0_0030);
    chk("drain_vld", 32'(valid_out), 32'h0);
    chk("drain_addr", instr_address_out, 32'h100);

    // Second redirect during drain wins
    step(0, 0, 0, 1, 32'h140, 0, 32'h0);
    step(0, 0, 0, 1, 32'h200, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 1, 32'hBAD0_0100);
    chk("redir2_addr", instr_address_out, 32'h200);
    fetch(32'h0000_0200);
    chk("redir2_pc", pc_out, 32'h200);

    // Reset during drain
    step(0, 0, 0, 1, 32'h300, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 0, 32'h0);
    chk("rstd_addr", instr_address_out, 32'h0);
    chk("rstd_read", 32'(instr_read_out), 32'h1);
    chk("rstd_vld", 32'(valid_out), 32'h0);
    wait_bus;
    chk("rstd_addr2", instr_address_out, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0,
           $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 2) != 0,
           $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_fetch_stage.md
RV32_FETCH_STAGE -- requirements
Module: rv32_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port stall_in  input  1  fetch stall from hazard unit.
REQ-005 SHALL have port flush_in  input  1  fetch flush from hazard unit.
REQ-006 SHALL have port branch_mispredicted_in  input  1  redirect request from mem stage.
REQ-007 SHALL have port branch_target_in  input  32  redirect target, valid with branch_mispredicted_in.
REQ-008 SHALL have port instr_address_out  output  32  instruction bus address.
REQ-009 SHALL have port instr_read_out  output  1  instruction bus read request.
REQ-010 SHALL have port instr_ready_in  input  1  bus read completes this cycle.
REQ-011 SHALL have port instr_read_value_in  input  32  read data, valid with instr_ready_in.
REQ-012 SHALL have ports pc_out (32), instr_out (32), valid_out (1), all outputs: registered fetch/decode pipeline register.

Function
REQ-013 SHALL hold a pc register and a two-state FSM: RUN, DRAIN; "complete" means instr_read_out && instr_ready_in.
REQ-014 SHALL drive instr_address_out = pc in both states; address stays stable from request until complete.
REQ-015 SHALL drive instr_read_out = 1 in DRAIN, and in RUN when hold_valid = 0; 0 otherwise.
REQ-016 RUN, complete, no redirect, stall_in = 0: output register loads {pc, data}, valid_out = 1 (unless flush_in); pc <= pc + 4 (mod 2^32).
REQ-017 RUN, complete, no redirect, stall_in = 1: data and pc captured into one-entry hold buffer, hold_valid <= 1, pc <= pc + 4; output register unchanged.
REQ-018 hold_valid = 1, stall_in = 0, no redirect: output register loads hold entry (valid_out = 1 unless flush_in), hold_valid <= 0; bus read resumes next cycle.
REQ-019 Redirect in RUN with no read pending-incomplete (read deasserted, or complete this cycle): pc <= target, hold_valid <= 0, returning data discarded, valid_out <= 0; state stays RUN.
REQ-020 Redirect in RUN with read asserted and instr_ready_in = 0: pending_target <= target, state <= DRAIN, valid_out <= 0, hold_valid <= 0.
REQ-021 DRAIN: read continues at old pc; a later redirect overwrites pending_target; on complete, data discarded, pc <= pending_target (or the new target if redirect same cycle), state <= RUN.
REQ-022 valid_out SHALL stay 0 throughout DRAIN.
REQ-023 Output register priority: redirect > flush_in (valid_out <= 0) > stall_in (hold all) > load per REQ-016/018 > valid_out <= 0 when nothing fetched.
REQ-024 flush_in SHALL NOT affect pc, hold buffer or FSM.
REQ-025 pc_out/instr_out SHALL be don't-care when valid_out = 0; verification checks them only while valid_out = 1.

Reset
REQ-026 reset_n = 0 at edge SHALL set pc = RESET_VECTOR, state = RUN, hold_valid = 0, valid_out = 0, pc_out = 0, instr_out = 0, pending_target = 0.
REQ-027 Reset mid-transaction (incl. DRAIN) SHALL abandon it; first post-reset cycle requests RESET_VECTOR with instr_read_out = 1.

Structure
REQ-028 FSM state enum and RV32 NOP constant (32'h0000_0013) SHALL live in shared package rv32_pkg; RESET_VECTOR stays a module parameter.
REQ-029 SHALL be a single module; no sub-module, hold buffer inline.
REQ-030 Combinational paths SHALL be limited to instr_address_out and instr_read_out from registered state.

Verification
REQ-031 Reset, then ready=1 every cycle, data = 0x13, 0x93, 0x113 -> valid_out=1 with pc_out 0x0, 0x4, 0x8 on consecutive cycles.
REQ-032 ready low 3 cycles at pc 0x10 -> address 0x10 held 4 cycles, valid_out=0 until complete, then pc_out=0x10.
REQ-033 stall_in=1 on completion of 0x20 for 2 cycles -> hold_valid=1, read_out=0, pc_out unchanged; stall drops -> pc_out=0x20 next cycle, read resumes at 0x24.
REQ-034 Redirect to 0x100 while 0x30 read waiting -> DRAIN, 0x30 data discarded on ready, next request 0x100, no valid_out=1 with pc_out=0x30.
REQ-035 Second redirect to 0x200 during DRAIN -> next request 0x200, not 0x100.
REQ-036 reset_n=0 during DRAIN -> next cycle address = RESET_VECTOR, state RUN, valid_out=0.
